// File: rtl/mul3_mac_vec_gadget.sv
// Masked ternary (mod 3) multiply-add / multiply-accumulate over LANES lanes,
// built from HPC2 gadgets on d-share Boolean masked coefficients.

// HPC2 gadget: 'b' is consumed one cycle before 'a', output valid 2 cycles after 'b'.
// With IS_OR set, it computes a | b via De Morgan (share 0 inverted on both sides).
module mul3_hpc2_gadget #(
    parameter int D     = 2,
    parameter bit IS_OR = 1'b0
) (
    input  logic                   clk,
    input  logic [D-1:0]           a,
    input  logic [D-1:0]           b,
    input  logic [D*(D-1)/2-1:0]   r,
    output logic [D-1:0]           c
);
    localparam int NR = D*(D-1)/2;
    localparam int NO = D*(D-1);
    localparam logic [D-1:0] FLIP = {{(D-1){1'b0}}, IS_OR};

    // index of the shared random bit for the unordered pair {i, j}
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo*D - (lo*(lo+1))/2 + (hi - lo - 1);
    endfunction

    // index of the ordered off-diagonal pair (i, j), i != j
    function automatic int ord_idx(input int i, input int j);
        return i*(D-1) + ((j < i) ? j : j-1);
    endfunction

    logic [D-1:0]  a_eff;
    logic [D-1:0]  b_eff;
    logic [D-1:0]  b_reg;
    logic [D-1:0]  self_reg;
    logic [D-1:0]  c_sum;
    logic [NR-1:0] r_reg;
    logic [NO-1:0] br_reg;
    logic [NO-1:0] neg_reg;
    logic [NO-1:0] pos_reg;

    assign a_eff = a ^ FLIP;
    assign b_eff = b ^ FLIP;

    always_ff @(posedge clk) begin
        b_reg    <= b_eff;
        r_reg    <= r;
        self_reg <= a_eff & b_reg;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                if (i != j) begin
                    br_reg[ord_idx(i, j)]  <= b_eff[j] ^ r[pair_idx(i, j)];
                    neg_reg[ord_idx(i, j)] <= ~a_eff[i] & r_reg[pair_idx(i, j)];
                    pos_reg[ord_idx(i, j)] <= a_eff[i] & br_reg[ord_idx(i, j)];
                end
            end
        end
    end

    // every cross term is registered before it is folded into an output share
    always_comb begin
        c_sum = self_reg;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                if (i != j) begin
                    c_sum[i] = c_sum[i] ^ neg_reg[ord_idx(i, j)] ^ pos_reg[ord_idx(i, j)];
                end
            end
        end
    end

    assign c = c_sum ^ FLIP;
endmodule

module mul3_mac_vec_gadget #(
    parameter int D     = 2,
    parameter int LANES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              mode_acc,
    input  logic                              acc_clear,
    input  logic [LANES*2*D-1:0]              e_in,
    input  logic [LANES*2*D-1:0]              v_in,
    input  logic [LANES*2*D-1:0]              a_in,
    input  logic [LANES*6*(D*(D-1)/2)-1:0]    rnd,
    output logic                              out_valid,
    output logic [LANES*2*D-1:0]              out_data
);
    localparam int NR = D*(D-1)/2;
    localparam int W  = 2*D;
    localparam logic [D-1:0] ONE0 = {{(D-1){1'b0}}, 1'b1};

    logic [4:0]           tok_valid_reg;
    logic [4:0]           tok_mode_reg;
    logic                 acc_in_flight;
    logic                 any_in_flight;
    logic                 accept;
    logic                 use_acc;
    logic [LANES*W-1:0]   a_op;
    logic [LANES*W-1:0]   core_out;
    logic [LANES*W-1:0]   acc_reg;
    logic [LANES*W-1:0]   out_data_reg;
    logic                 out_valid_reg;

    assign acc_in_flight = |(tok_valid_reg & tok_mode_reg);
    assign any_in_flight = |tok_valid_reg;
    // an accumulate beat needs an empty pipeline; a stream beat only needs no accumulate in flight
    assign in_ready = ~rst & ~acc_in_flight & ~(in_valid & mode_acc & any_in_flight);
    assign accept   = in_valid & in_ready;

    assign use_acc = mode_acc & ~acc_clear;
    assign a_op    = use_acc ? acc_reg : a_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_valid_reg <= '0;
            tok_mode_reg  <= '0;
        end else begin
            tok_valid_reg <= {tok_valid_reg[3:0], accept};
            tok_mode_reg  <= {tok_mode_reg[3:0], mode_acc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            acc_reg       <= '0;
        end else begin
            out_valid_reg <= tok_valid_reg[4];
            if (tok_valid_reg[4]) begin
                out_data_reg <= core_out;
            end
            if (tok_valid_reg[4] & tok_mode_reg[4]) begin
                acc_reg <= core_out;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [D-1:0] e0, e1, v0, v1, a0, a1;
        logic [D-1:0] e0_d1_reg;
        logic [D-1:0] w_d1_reg;
        logic [D-1:0] t_d4_reg;
        logic [D-1:0] a0_pipe_reg [1:5];
        logic [D-1:0] a1_pipe_reg [1:5];
        logic [D-1:0] r0_pipe_reg [3:5];
        logic [D-1:0] r1_pipe_reg [4:5];
        logic [D-1:0] r0, r1, t, m, u, xn, nt, or_out, c1, s0, s1;

        assign e0 = e_in[gi*W +: D];
        assign e1 = e_in[gi*W + D +: D];
        assign v0 = v_in[gi*W +: D];
        assign v1 = v_in[gi*W + D +: D];
        assign a0 = a_op[gi*W +: D];
        assign a1 = a_op[gi*W + D +: D];

        // data-path shares need no reset: stale contents are masked by the token pipeline
        always_ff @(posedge clk) begin
            e0_d1_reg      <= e0;
            w_d1_reg       <= e1 ^ v1;
            a0_pipe_reg[1] <= a0;
            a1_pipe_reg[1] <= a1;
            for (int k = 2; k <= 5; k++) begin
                a0_pipe_reg[k] <= a0_pipe_reg[k-1];
                a1_pipe_reg[k] <= a1_pipe_reg[k-1];
            end
            r0_pipe_reg[3] <= r0;
            r0_pipe_reg[4] <= r0_pipe_reg[3];
            r0_pipe_reg[5] <= r0_pipe_reg[4];
            r1_pipe_reg[4] <= r1;
            r1_pipe_reg[5] <= r1_pipe_reg[4];
            t_d4_reg       <= t;
        end

        // product nonzero flag r0 = e0 & v0 (cycle 2), sign r1 = (e1 ^ v1) & r0 (cycle 3)
        mul3_hpc2_gadget #(.D(D), .IS_OR(1'b0)) u_g0 (
            .clk (clk), .a (e0_d1_reg), .b (v0),
            .r (rnd[(gi*6+0)*NR +: NR]), .c (r0)
        );
        mul3_hpc2_gadget #(.D(D), .IS_OR(1'b0)) u_g1 (
            .clk (clk), .a (r0), .b (w_d1_reg),
            .r (rnd[(gi*6+1)*NR +: NR]), .c (r1)
        );

        // both-nonzero flag t (cycle 3) and both-negative flag m (cycle 4)
        mul3_hpc2_gadget #(.D(D), .IS_OR(1'b0)) u_g2 (
            .clk (clk), .a (r0), .b (a0_pipe_reg[1]),
            .r (rnd[(gi*6+2)*NR +: NR]), .c (t)
        );
        mul3_hpc2_gadget #(.D(D), .IS_OR(1'b0)) u_g3 (
            .clk (clk), .a (r1), .b (a1_pipe_reg[2]),
            .r (rnd[(gi*6+3)*NR +: NR]), .c (m)
        );

        // u = t & (signs equal); c1 = ~(~t | m) = t & ~m, both at cycle 5
        assign xn = r1 ^ a1_pipe_reg[3] ^ ONE0;
        assign nt = t ^ ONE0;
        mul3_hpc2_gadget #(.D(D), .IS_OR(1'b0)) u_g4 (
            .clk (clk), .a (t_d4_reg), .b (xn),
            .r (rnd[(gi*6+4)*NR +: NR]), .c (u)
        );
        mul3_hpc2_gadget #(.D(D), .IS_OR(1'b1)) u_g5 (
            .clk (clk), .a (m), .b (nt),
            .r (rnd[(gi*6+5)*NR +: NR]), .c (or_out)
        );
        assign c1 = or_out ^ ONE0;

        // sum mod 3: s0 = x0^y0^(t & x1==y1), s1 = x1^y1^(t & ~(x1&y1))
        assign s0 = r0_pipe_reg[5] ^ a0_pipe_reg[5] ^ u;
        assign s1 = r1_pipe_reg[5] ^ a1_pipe_reg[5] ^ c1;
        assign core_out[gi*W +: W] = {s1, s0};
    end
endmodule

// File: tb/tb_mul3_mac_vec_gadget.sv
// Randomised self-checking bench for mul3_mac_vec_gadget against a plain
// mod-3 arithmetic model with an in-order expected-result queue.
module tb_mul3_mac_vec_gadget;
    localparam int D     = 2;
    localparam int LANES = 2;
    localparam int W     = 2*D;
    localparam int NR    = D*(D-1)/2;
    localparam int RW    = LANES*6*NR;
    localparam int DW    = LANES*W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          mode_acc;
    logic          acc_clear;
    logic [DW-1:0] e_in;
    logic [DW-1:0] v_in;
    logic [DW-1:0] a_in;
    logic [RW-1:0] rnd;
    logic          out_valid;
    logic [DW-1:0] out_data;

    mul3_mac_vec_gadget #(.D(D), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_acc  (mode_acc),
        .acc_clear (acc_clear),
        .e_in      (e_in),
        .v_in      (v_in),
        .a_in      (a_in),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_cyc_q[$];
    logic [2*LANES-1:0] exp_val_q[$];
    int model_acc [LANES];
    logic [DW-1:0] last_out_raw;
    int be [LANES];
    int bv [LANES];
    int ba [LANES];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] enc(input int v);
        if (v == 0) return 2'b00;
        if (v > 0)  return 2'b01;
        return 2'b11;
    endfunction

    function automatic int dec(input logic [1:0] p);
        if (p == 2'b01) return 1;
        if (p == 2'b11) return -1;
        return 0;
    endfunction

    function automatic int mod3(input int x);
        int r;
        r = ((x % 3) + 3) % 3;
        return (r == 2) ? -1 : r;
    endfunction

    function automatic int rand_val();
        return int'($urandom_range(0, 2)) - 1;
    endfunction

    function automatic logic [W-1:0] mask_val(input int v);
        logic [1:0]   p;
        logic [D-1:0] s0;
        logic [D-1:0] s1;
        p = enc(v);
        s0 = D'($urandom);
        s1 = D'($urandom);
        s0[D-1] = (^s0[D-2:0]) ^ p[0];
        s1[D-1] = (^s1[D-2:0]) ^ p[1];
        return {s1, s0};
    endfunction

    function automatic logic [1:0] unmask_lane(input logic [W-1:0] x);
        return {^x[W-1:D], ^x[D-1:0]};
    endfunction

    function automatic logic [2*LANES-1:0] unmask_all(input logic [DW-1:0] x);
        logic [2*LANES-1:0] r;
        for (int l = 0; l < LANES; l++) r[2*l +: 2] = unmask_lane(x[l*W +: W]);
        return r;
    endfunction

    // fresh randomness every cycle, idle or not
    initial begin
        rnd = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < RW; i++) rnd[i] = 1'($urandom);
        end
    end

    // monitor: checks each output against the queue and records accepted beats
    always @(negedge clk) begin
        logic [2*LANES-1:0] exp_v;
        int ev, vv, av, base, res;
        cyc++;
        if (exp_cyc_q.size() > 0 && cyc == exp_cyc_q[0] + 6) begin
            check_eq("out_valid_latency", 64'(out_valid), 64'(1));
            if (out_valid) check_eq("out_value", 64'(unmask_all(out_data)), 64'(exp_val_q[0]));
            void'(exp_cyc_q.pop_front());
            void'(exp_val_q.pop_front());
        end else begin
            check_eq("no_spurious_valid", 64'(out_valid), 64'(0));
        end
        if (out_valid) last_out_raw = out_data;
        if (rst) begin
            exp_cyc_q.delete();
            exp_val_q.delete();
            for (int l = 0; l < LANES; l++) model_acc[l] = 0;
        end else if (in_valid && in_ready) begin
            for (int l = 0; l < LANES; l++) begin
                ev = dec(unmask_lane(e_in[l*W +: W]));
                vv = dec(unmask_lane(v_in[l*W +: W]));
                av = dec(unmask_lane(a_in[l*W +: W]));
                if (mode_acc) begin
                    base = acc_clear ? av : model_acc[l];
                    res = mod3(ev*vv + base);
                    model_acc[l] = res;
                end else begin
                    res = mod3(ev*vv + av);
                end
                exp_v[2*l +: 2] = enc(res);
            end
            exp_cyc_q.push_back(cyc);
            exp_val_q.push_back(exp_v);
        end
    end

    task automatic load_beat(input logic m, input logic clr);
        mode_acc  = m;
        acc_clear = clr;
        in_valid  = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            e_in[l*W +: W] = mask_val(be[l]);
            v_in[l*W +: W] = mask_val(bv[l]);
            a_in[l*W +: W] = mask_val(ba[l]);
        end
    endtask

    task automatic randomize_beat();
        for (int l = 0; l < LANES; l++) begin
            be[l] = rand_val();
            bv[l] = rand_val();
            ba[l] = rand_val();
        end
    endtask

    // hold the offer until accepted (bounded); returns cycles spent waiting
    task automatic wait_accept(input string tag, output int waited);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        check_eq(tag, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // accumulate beat: ready must stay low for 5 cycles, then return in the result cycle
    task automatic acc_beat(input logic clr);
        int w;
        load_beat(1'b1, clr);
        wait_accept("acc_accept", w);
        check_eq("acc_accept_no_wait", 64'(w), 64'(0));
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq("acc_busy_ready_low", 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stalls;
        logic [DW-1:0] raws [4];
        logic any_diff;

        rst = 1'b1; in_valid = 1'b0; mode_acc = 1'b0; acc_clear = 1'b0;
        e_in = '0; v_in = '0; a_in = '0;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_in_ready", 64'(in_ready), 64'(0));
        end
        check_eq("reset_out_valid", 64'(out_valid), 64'(0));
        check_eq("reset_out_data", 64'(out_data), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // directed streaming beat
        be[0] = 1;  bv[0] = -1; ba[0] = -1;
        be[1] = 0;  bv[1] = 1;  ba[1] = 1;
        load_beat(1'b0, 1'b0);
        wait_accept("stream_accept", w);
        idle(8);
        check_eq("directed_stream", 64'(unmask_all(last_out_raw)), 64'(4'b0101));

        // 200 back-to-back random stream beats
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            randomize_beat();
            load_beat(1'b0, 1'b0);
            wait_accept("b2b_accept", w);
            stalls += w;
        end
        check_eq("b2b_no_stalls", 64'(stalls), 64'(0));
        idle(8);

        // accumulate: clear with 0 + 1*1, then +1*+1, then -1*+1 -> +1, -1, +1
        for (int l = 0; l < LANES; l++) begin be[l] = 1; bv[l] = 1; ba[l] = 0; end
        acc_beat(1'b1);
        for (int l = 0; l < LANES; l++) begin be[l] = 1; bv[l] = 1; ba[l] = rand_val(); end
        acc_beat(1'b0);
        be[0] = -1; bv[0] = 1; ba[0] = rand_val();
        be[1] = rand_val(); bv[1] = rand_val(); ba[1] = rand_val();
        acc_beat(1'b0);
        idle(3);
        check_eq("acc_seq_lane0", 64'(unmask_lane(last_out_raw[W-1:0])), 64'(2'b01));

        // mode switch: stream beat then accumulate beat offered the next cycle
        randomize_beat();
        load_beat(1'b0, 1'b0);
        wait_accept("switch_stream_accept", w);
        for (int l = 0; l < LANES; l++) begin be[l] = 0; bv[l] = rand_val(); ba[l] = rand_val(); end
        load_beat(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq("switch_blocked", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        wait_accept("switch_acc_accept", w);
        check_eq("switch_accept_in_result_cycle", 64'(w), 64'(0));
        idle(8);
        check_eq("acc_unchanged_by_stream", 64'(unmask_lane(last_out_raw[W-1:0])), 64'(2'b01));

        // reset mid-flight
        for (int i = 0; i < 3; i++) begin
            randomize_beat();
            load_beat(1'b0, 1'b0);
            wait_accept("rst_stream_accept", w);
        end
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);
        @(negedge clk);
        check_eq("out_data_after_reset", 64'(out_data), 64'(0));
        @(posedge clk); #1;
        for (int l = 0; l < LANES; l++) begin be[l] = 0; bv[l] = rand_val(); ba[l] = rand_val(); end
        load_beat(1'b1, 1'b0);
        wait_accept("post_rst_acc_accept", w);
        idle(8);
        check_eq("acc_zero_after_reset", 64'(unmask_all(last_out_raw)), 64'(0));

        // masking sanity: same values, new share splits and randomness
        randomize_beat();
        be[0] = 1; bv[0] = 1;
        for (int run = 0; run < 4; run++) begin
            load_beat(1'b0, 1'b0);
            wait_accept("mask_accept", w);
            idle(8);
            raws[run] = last_out_raw;
        end
        any_diff = 1'b0;
        for (int run = 1; run < 4; run++) begin
            check_eq("mask_same_value", 64'(unmask_all(raws[run])), 64'(unmask_all(raws[0])));
            if (raws[run] != raws[0]) any_diff = 1'b1;
        end
        check_eq("mask_shares_vary", 64'(any_diff), 64'(1));

        // random mix of modes, clears and gaps
        for (int i = 0; i < 40; i++) begin
            logic m;
            randomize_beat();
            m = 1'($urandom_range(0, 1));
            load_beat(m, m && ($urandom_range(0, 3) == 0));
            wait_accept("mix_accept", w);
            idle(int'($urandom_range(0, 2)));
        end
        idle(10);
        check_eq("queue_drained", 64'(exp_cyc_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mul3_mac_vec_gadget.md
Name: mul3_mac_vec_gadget

Overview:
- Vectorised, masked ternary multiply-add (mod 3) for the NTRU Prime polynomial multiplier datapath.
- Processes LANES coefficients per accepted beat, each in d-share Boolean masking.
- Two modes:
  - Streaming (out = a + e·v, one beat/cycle).
  - Accumulate (out = acc + e·v, internal masked accumulator per lane), with a valid/ready front end.
- Composition is HPC2 AND/OR gadgets only; sits between the coefficient sampler and the masked polynomial accumulator.

Parameters:
- d, 2, number of shares (≥2).
- LANES, 4, parallel coefficient lanes (≥1).
- NR (localparam), d*(d-1)/2, random bits per HPC2 gadget.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat offered.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- mode_acc  in  1  0 = streaming, 1 = accumulate; sampled with the beat.
- acc_clear  in  1  accumulate mode only: seed the accumulator from a_in for this beat.
- e_in  in  LANES*2*d  masked ternary operand e.
- v_in  in  LANES*2*d  masked ternary operand v.
- a_in  in  LANES*2*d  masked addend (streaming) or accumulator seed (acc_clear).
- rnd  in  LANES*6*NR  fresh randomness, every cycle.
- out_valid  out  1  out_data valid this cycle.
- out_data  out  LANES*2*d  masked ternary result.

Behaviour:
- Encoding, per lane:
  - Bits [2d-1:0] of the lane slice; plane0 (nonzero flag) = low d bits, plane1 (sign) = high d bits.
  - Unmasked plane = XOR of its shares.
  - Values: 0 = (p1,p0) = (0,0); +1 = (0,1); −1 = (1,1); (1,0) is never produced.
- Per-lane core:
  - Six HPC2 gadgets (5 AND, 1 OR) computing r = e·v, then r + a mod 3.
  - Gadget k of lane L uses rnd[(L*6+k)*NR +: NR].
  - The e operand is delayed so every AND input pair is share-aligned.
  - No unmasked value is ever formed; no share recombination.
- Latency and output register:
  - Core latency is 5 cycles.
  - out_data is a register loaded when the core's valid token emerges, giving 6 cycles from accept to out_valid.
  - out_data holds its value between results; out_valid is a 1-cycle pulse per beat.
- Valid pipeline: a 5-stage shift register of {valid, mode} tokens travels alongside the data.
- Streaming mode:
  - in_ready = 1; one beat per cycle; a operand = a_in.
  - The accumulator is untouched.
- Accumulate mode:
  - a operand = acc_reg[L], or a_in if acc_clear.
  - On the result cycle, acc_reg ← result, written in the same edge as out_data.
  - in_ready = 0 while an accumulate beat is in flight (5 core cycles).
  - in_ready rises in the cycle out_valid is asserted, so max throughput is 1 beat per 6 cycles.
  - A beat accepted in that cycle sees the updated acc_reg (no bypass needed: the register is written at the same edge).
- Mode switch:
  - in_ready is deasserted while any token of the other mode is in flight.
  - The pipeline therefore never mixes modes.
  - mode_acc is ignored when in_valid = 0.
- Randomness: the caller supplies fresh rnd every cycle, including idle cycles. Reusing rnd is a caller error; the block does not check it.
- Reset:
  - Clears the token pipeline, out_valid = 0, out_data = 0, acc_reg = all shares 0 (value 0), in_ready = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
- Reset mid-operation: in-flight beats are discarded with no out_valid; data-path registers may hold stale shares, but their outputs are gated by valid.
- Boundaries:
  - in_valid held with in_ready = 0: nothing is accepted, and the caller holds the data.
  - acc_clear with mode_acc = 0: ignored.
  - LANES = 1 and d = 2 must elaborate.
  - Accumulator wrap-around is inherent mod 3.

Test Plan:
- Streaming, d=2, LANES=2, random masks:
  - Lane0 e=+1, v=−1, a=−1; lane1 e=0, v=+1, a=+1.
  - Expected: unmasked out lane0 = +1 (1,1→(0,1)), lane1 = +1, out_valid exactly 6 cycles after accept.
- Streaming, back-to-back:
  - 200 consecutive random beats with fresh rnd.
  - Expected: in_ready stays 1 and every output matches the mod-3 reference model in order, 6 cycles later.
- Accumulate:
  - acc_clear beat a=0, e=+1, v=+1, then beats (+1,+1), (−1,+1).
  - Expected: outputs +1, −1, +1; in_ready low 5 cycles after each accept; next accept possible in the out_valid cycle.
- Mode switch:
  - Stream beat at cycle t, accumulate beat offered at t+1.
  - Expected: in_ready = 0 until the stream result emerges; the accumulate beat is accepted afterwards, and acc_reg is unchanged by the stream beat.
- Reset mid-flight:
  - Three stream beats accepted, rst pulsed 2 cycles later.
  - Expected: no out_valid; out_data = 0; acc_reg reads 0 via a subsequent accumulate beat with e=0.
- Masking sanity:
  - Same unmasked inputs with different share splits and rnd.
  - Expected: identical unmasked outputs; individual output shares differ across runs.
